// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage CPU.
// Produces per-stage load enables and bubble controls for the F/D, D/E,
// E/M and M/W registers, the exception-entry flush (Req) and the next-PC
// source. Arbitrates exception entry, data-bus wait, eret redirect and
// data-hazard stalls; defers exceptions raised during a bus wait, forces a
// bus-timeout exception after TIMEOUT consecutive wait cycles and keeps a
// saturating count of stalled cycles.
//
// Exception entry (Req=1, pc_sel=1) always drives every enable to 1, whether
// the exception comes from RUN, from a deferred request at the end of a bus
// wait, or from a bus timeout: the PC must load the handler address and the
// pipeline registers must take the Req flush in that cycle.
module pipe_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic        mem_wait,
    input  logic        eret_D,
    input  logic        epc_busy,
    input  logic        stall_hazard,
    output logic        F_enable,
    output logic        D_enable,
    output logic        E_enable,
    output logic        M_enable,
    output logic        W_enable,
    output logic        D_flush,
    output logic        E_flush,
    output logic        Req,
    output logic [1:0]  pc_sel,
    output logic        bus_timeout,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        EXC  = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ     = 2'd0;
    localparam logic [1:0] PC_HANDLER = 2'd1;
    localparam logic [1:0] PC_EPC     = 2'd2;

    // Counter value seen in the cycle that is the TIMEOUT-th mem_wait cycle:
    // the counter is loaded with 1 when the wait starts (that first cycle
    // already counts), so it lags the mem_wait cycle number by one.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    // Hazard stall: hold F and D, let E, M and W drain.
    localparam logic [4:0] EN_HAZ  = 5'b00111;

    state_t      state_reg, state_next;
    logic        pending_reg, pending_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] stall_cnt_reg;

    // Raw controls before reset gating; enables ordered F, D, E, M, W.
    logic [4:0]  enables;
    logic        d_flush;
    logic        e_flush;
    logic        req;
    logic [1:0]  pc_src;
    logic        timeout_hit;
    logic        run_rules;
    logic        exc_allowed;
    logic        stall_event;

    // State, deferred-exception flag and bus-wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RUN;
            pending_reg  <= 1'b0;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state and control decode; RUN rules are shared by RUN, EXC and
    // the quiet exit from WAIT.
    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        wait_cnt_next = wait_cnt_reg;
        enables       = EN_ALL;
        d_flush       = 1'b0;
        e_flush       = 1'b0;
        req           = 1'b0;
        pc_src        = PC_SEQ;
        timeout_hit   = 1'b0;
        run_rules     = 1'b0;
        exc_allowed   = 1'b0;

        case (state_reg)
            RUN: begin
                run_rules   = 1'b1;
                exc_allowed = 1'b1;
            end

            // One cycle after exception entry: the request that caused it
            // may still be asserted, so it is ignored here.
            EXC: begin
                run_rules   = 1'b1;
                exc_allowed = 1'b0;
            end

            WAIT: begin
                if (mem_wait) begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        // Bus timeout wins over everything, including a
                        // deferred request, which it subsumes.
                        timeout_hit   = 1'b1;
                        req           = 1'b1;
                        pc_src        = PC_HANDLER;
                        pending_next  = 1'b0;
                        wait_cnt_next = 8'd0;
                        state_next    = EXC;
                    end else begin
                        enables       = EN_NONE;
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                        if (exc_req) begin
                            pending_next = 1'b1;
                        end
                    end
                end else if (pending_reg || exc_req) begin
                    // Deferred (or just-arrived) exception taken on the
                    // first cycle the bus is ready.
                    req           = 1'b1;
                    pc_src        = PC_HANDLER;
                    pending_next  = 1'b0;
                    wait_cnt_next = 8'd0;
                    state_next    = EXC;
                end else begin
                    wait_cnt_next = 8'd0;
                    run_rules     = 1'b1;
                    exc_allowed   = 1'b1;
                end
            end

            default: begin
                state_next    = RUN;
                pending_next  = 1'b0;
                wait_cnt_next = 8'd0;
            end
        endcase

        if (run_rules) begin
            if (exc_allowed && exc_req) begin
                req        = 1'b1;
                pc_src     = PC_HANDLER;
                state_next = EXC;
            end else if (mem_wait) begin
                enables       = EN_NONE;
                wait_cnt_next = 8'd1;
                state_next    = WAIT;
            end else begin
                state_next = RUN;
                if (eret_D && !epc_busy) begin
                    // Redirect to EPC and kill the slot fetched behind eret.
                    pc_src  = PC_EPC;
                    d_flush = 1'b1;
                end else if (eret_D || stall_hazard) begin
                    // eret waiting on an in-flight EPC write stalls like a
                    // data hazard.
                    enables = EN_HAZ;
                    e_flush = 1'b1;
                end
            end
        end
    end

    // Drive the ports; every control is forced inactive while reset is low.
    always_comb begin
        if (reset) begin
            {F_enable, D_enable, E_enable, M_enable, W_enable} = enables;
            D_flush     = d_flush;
            E_flush     = e_flush;
            Req         = req;
            pc_sel      = pc_src;
            bus_timeout = timeout_hit;
        end else begin
            {F_enable, D_enable, E_enable, M_enable, W_enable} = EN_NONE;
            D_flush     = 1'b0;
            E_flush     = 1'b0;
            Req         = 1'b0;
            pc_sel      = PC_SEQ;
            bus_timeout = 1'b0;
        end
    end

    // A cycle counts as stalled when any register is held or E is bubbled.
    assign stall_event = (enables != EN_ALL) || e_flush;

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 32'd0;
        end else if (stall_event && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios with constant expectations,
// then randomized traffic checked against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 16;

    // Control word layout: {F,D,E,M,W enables, D_flush, E_flush, Req,
    // pc_sel[1:0], bus_timeout}.
    localparam logic [10:0] CTL_RESET  = 11'b00000_00_0_00_0;
    localparam logic [10:0] CTL_IDLE   = 11'b11111_00_0_00_0;
    localparam logic [10:0] CTL_FREEZE = 11'b00000_00_0_00_0;
    localparam logic [10:0] CTL_HAZ    = 11'b00111_01_0_00_0;
    localparam logic [10:0] CTL_EXC    = 11'b11111_00_1_01_0;
    localparam logic [10:0] CTL_ERET   = 11'b11111_10_0_10_0;
    localparam logic [10:0] CTL_TMO    = 11'b11111_00_1_01_1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exc_req = 1'b0;
    logic        mem_wait = 1'b0;
    logic        eret_D = 1'b0;
    logic        epc_busy = 1'b0;
    logic        stall_hazard = 1'b0;
    logic        F_enable, D_enable, E_enable, M_enable, W_enable;
    logic        D_flush, E_flush, Req, bus_timeout;
    logic [1:0]  pc_sel;
    logic [31:0] stall_cnt;
    logic [10:0] ctl;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .exc_req      (exc_req),
        .mem_wait     (mem_wait),
        .eret_D       (eret_D),
        .epc_busy     (epc_busy),
        .stall_hazard (stall_hazard),
        .F_enable     (F_enable),
        .D_enable     (D_enable),
        .E_enable     (E_enable),
        .M_enable     (M_enable),
        .W_enable     (W_enable),
        .D_flush      (D_flush),
        .E_flush      (E_flush),
        .Req          (Req),
        .pc_sel       (pc_sel),
        .bus_timeout  (bus_timeout),
        .stall_cnt    (stall_cnt)
    );

    assign ctl = {F_enable, D_enable, E_enable, M_enable, W_enable,
                  D_flush, E_flush, Req, pc_sel, bus_timeout};

    always #5 clk = ~clk;

    // Apply one cycle of inputs {exc_req, mem_wait, eret_D, epc_busy,
    // stall_hazard} just after a rising edge; return at the falling edge.
    task automatic drive(input logic [4:0] v);
        @(posedge clk);
        #1;
        {exc_req, mem_wait, eret_D, epc_busy, stall_hazard} = v;
        @(negedge clk);
    endtask

    // Pulse reset from a falling edge; released on the next falling edge.
    task automatic do_reset();
        {exc_req, mem_wait, eret_D, epc_busy, stall_hazard} = 5'b00000;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ctl !== CTL_RESET) begin
            errors++;
            $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RESET);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        // Active inputs must not leak through while reset is low.
        {exc_req, mem_wait, eret_D, epc_busy, stall_hazard} = 5'b10111;
        #1;
        checks++;
        if (ctl !== CTL_RESET) begin
            errors++;
            $display("FAIL reset_gated_ctl: got %b want %b", ctl, CTL_RESET);
        end
        {exc_req, mem_wait, eret_D, epc_busy, stall_hazard} = 5'b00000;
        @(negedge clk);
        reset = 1'b1;
        drive(5'b00000);
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++;
            $display("FAIL reset_first_run: got %b want %b", ctl, CTL_IDLE);
        end else begin
            $display("reset: first cycle ctl=%b stall_cnt=%0d", ctl, stall_cnt);
        end
    endtask

    task automatic test_hazard();
        logic [4:0]  stim [3] = '{5'b00001, 5'b00001, 5'b00000};
        logic [10:0] expv [3] = '{CTL_HAZ, CTL_HAZ, CTL_IDLE};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(stim[c]);
            checks++;
            if (ctl !== expv[c]) begin
                errors++;
                $display("FAIL hazard_ctl cyc %0d: got %b want %b", c + 1, ctl, expv[c]);
            end else begin
                $display("hazard cyc %0d ctl=%b stall_cnt=%0d", c + 1, ctl, stall_cnt);
            end
        end
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL hazard_stall_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_exception();
        // Pulse, held request masked in EXC, then exc_req+mem_wait together.
        logic [4:0]  stim [6] = '{5'b10000, 5'b10000, 5'b00000,
                                  5'b11000, 5'b01000, 5'b00000};
        logic [10:0] expv [6] = '{CTL_EXC, CTL_IDLE, CTL_IDLE,
                                  CTL_EXC, CTL_FREEZE, CTL_IDLE};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(stim[c]);
            checks++;
            if (ctl !== expv[c]) begin
                errors++;
                $display("FAIL exception_ctl cyc %0d: got %b want %b", c + 1, ctl, expv[c]);
            end else begin
                $display("exception cyc %0d ctl=%b", c + 1, ctl);
            end
        end
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL exception_stall_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_deferred();
        logic [4:0]  stim [7] = '{5'b01000, 5'b11000, 5'b01000, 5'b01000,
                                  5'b01000, 5'b00000, 5'b00000};
        logic [10:0] expv [7] = '{CTL_FREEZE, CTL_FREEZE, CTL_FREEZE, CTL_FREEZE,
                                  CTL_FREEZE, CTL_EXC, CTL_IDLE};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(stim[c]);
            checks++;
            if (ctl !== expv[c]) begin
                errors++;
                $display("FAIL deferred_ctl cyc %0d: got %b want %b", c + 1, ctl, expv[c]);
            end else begin
                $display("deferred cyc %0d ctl=%b", c + 1, ctl);
            end
        end
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL deferred_stall_cnt: got %0d want 5", stall_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] expv;
        do_reset();
        for (int c = 1; c <= 21; c++) begin
            drive({1'b0, (c <= 20), 3'b000});
            if (c == TIMEOUT)      expv = CTL_TMO;
            else if (c <= 20)      expv = CTL_FREEZE;
            else                   expv = CTL_IDLE;
            checks++;
            if (ctl !== expv) begin
                errors++;
                $display("FAIL timeout_ctl cyc %0d: got %b want %b", c, ctl, expv);
            end else begin
                $display("timeout cyc %0d ctl=%b", c, ctl);
            end
        end
        checks++;
        if (stall_cnt !== 32'd19) begin
            errors++;
            $display("FAIL timeout_stall_cnt: got %0d want 19", stall_cnt);
        end
    endtask

    task automatic test_eret();
        logic [4:0]  stim [3] = '{5'b00110, 5'b00100, 5'b00000};
        logic [10:0] expv [3] = '{CTL_HAZ, CTL_ERET, CTL_IDLE};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(stim[c]);
            checks++;
            if (ctl !== expv[c]) begin
                errors++;
                $display("FAIL eret_ctl cyc %0d: got %b want %b", c + 1, ctl, expv[c]);
            end else begin
                $display("eret cyc %0d ctl=%b", c + 1, ctl);
            end
        end
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL eret_stall_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(5'b01000);
        drive(5'b11000);
        drive(5'b01000);
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL midwait_stall_cnt_pre: got %0d want 2", stall_cnt);
        end
        // Assert reset between edges with mem_wait still high.
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RESET) begin
            errors++;
            $display("FAIL midwait_reset_ctl: got %b want %b", ctl, CTL_RESET);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midwait_reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        mem_wait = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            drive(5'b00000);
            checks++;
            if (ctl !== CTL_IDLE) begin
                errors++;
                $display("FAIL midwait_after_ctl cyc %0d: got %b want %b", c, ctl, CTL_IDLE);
            end else begin
                $display("midwait after-reset cyc %0d ctl=%b", c, ctl);
            end
        end
    endtask

    task automatic test_random();
        int      burst = 0;
        int      m_bus = 0;       // mem_wait cycles so far in current bus wait
        bit      m_def = 1'b0;    // exception deferred by the bus wait
        bit      m_mask = 1'b0;   // an exception was taken last cycle
        longint  m_stalls = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic        e, mw, er, eb, sh;
            logic [10:0] expv;
            bit          took;
            bit          normal;
            if (burst == 0 && $urandom_range(0, 5) == 0) begin
                burst = $urandom_range(1, 22);
            end
            mw = (burst > 0);
            if (burst > 0) burst--;
            e  = ($urandom_range(0, 7) == 0);
            er = ($urandom_range(0, 7) == 0);
            eb = $urandom_range(0, 1) == 1;
            sh = ($urandom_range(0, 4) == 0);
            drive({e, mw, er, eb, sh});

            took   = 1'b0;
            normal = 1'b1;
            expv   = CTL_IDLE;
            if (m_bus > 0) begin
                normal = 1'b0;
                if (mw) begin
                    if (m_bus + 1 == TIMEOUT) begin
                        expv  = CTL_TMO;
                        took  = 1'b1;
                        m_def = 1'b0;
                        m_bus = 0;
                    end else begin
                        expv = CTL_FREEZE;
                        m_bus++;
                        if (e) m_def = 1'b1;
                    end
                end else if (m_def || e) begin
                    expv  = CTL_EXC;
                    took  = 1'b1;
                    m_def = 1'b0;
                    m_bus = 0;
                end else begin
                    m_bus  = 0;
                    normal = 1'b1;
                end
            end
            if (normal) begin
                if (e && !m_mask) begin
                    expv = CTL_EXC;
                    took = 1'b1;
                end else if (mw) begin
                    expv  = CTL_FREEZE;
                    m_bus = 1;
                end else if (er && !eb) begin
                    expv = CTL_ERET;
                end else if (er || sh) begin
                    expv = CTL_HAZ;
                end
            end

            checks++;
            if (ctl !== expv) begin
                errors++;
                $display("FAIL random_ctl n=%0d in=%b%b%b%b%b: got %b want %b",
                         n, e, mw, er, eb, sh, ctl, expv);
            end else begin
                $display("random n=%0d in=%b%b%b%b%b ctl=%b stall_cnt=%0d",
                         n, e, mw, er, eb, sh, ctl, stall_cnt);
            end
            checks++;
            if (stall_cnt !== 32'(m_stalls)) begin
                errors++;
                $display("FAIL random_stall_cnt n=%0d: got %0d want %0d", n, stall_cnt, m_stalls);
            end

            m_mask = took;
            if ((expv[10:6] != 5'b11111 || expv[4]) && m_stalls < 64'hFFFF_FFFF) begin
                m_stalls++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_exception();
        test_deferred();
        test_timeout();
        test_eret();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
